// File: rtl/booth_multiplier.sv
// Signed 8x8 radix-4 Booth multiplier with a registered 16-bit product.
// Optional macro BOOTH_PIPE_EN adds a register stage after Booth recoding.
// The optional stage raises latency from 1 to 2 cycles. Results are identical in both builds.
module booth_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  output logic [15:0] result
);

  // A recoded digit is negative for groups 100, 101 and 110.
  // Group 111 is a zero digit, so it never requests a carry-in.
  function automatic logic booth_neg(input logic [2:0] grp);
    return (grp == 3'b100) || (grp == 3'b101) || (grp == 3'b110);
  endfunction

  // Forms the 10-bit partial product for one recoded group.
  // Negative digits return the ones' complement of the magnitude; booth_sum adds the +1.
  function automatic logic [9:0] booth_pp(input logic [2:0] grp, input logic signed [7:0] a);
    logic [9:0] a1;
    logic [9:0] a2;
    logic [9:0] mag;
    a1 = {{2{a[7]}}, a};
    a2 = {a[7], a, 1'b0};
    case (grp)
      3'b001, 3'b010, 3'b101, 3'b110: mag = a1;
      3'b011, 3'b100:                 mag = a2;
      default:                        mag = '0;
    endcase
    return booth_neg(grp) ? ~mag : mag;
  endfunction

  // Sign-extends each partial product and places it at weight 4^i.
  // The two's-complement carry-in bit goes to the same weight.
  // The sum is taken modulo 2^16.
  function automatic logic [15:0] booth_sum(input logic [3:0][9:0] pp, input logic [3:0] neg);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + ({{6{pp[i][9]}}, pp[i]} << (2 * i)) + (16'(neg[i]) << (2 * i));
    end
    return acc;
  endfunction

  logic [8:0]       bx;
  logic [3:0][9:0]  pp_d;
  logic [3:0]       neg_d;
  logic             sum_vld;
  logic [15:0]      sum_d;
  logic             out_valid_q;
  logic [15:0]      result_q;

  // Booth recoding: B with an implicit zero below the LSB, split into overlapping triplets
  always_comb begin
    bx    = {B, 1'b0};
    pp_d  = '0;
    neg_d = '0;
    for (int i = 0; i < 4; i++) begin
      pp_d[i]  = booth_pp(bx[2*i +: 3], A);
      neg_d[i] = booth_neg(bx[2*i +: 3]);
    end
  end

`ifdef BOOTH_PIPE_EN
  logic [3:0][9:0] pp_p0_q;
  logic [3:0]      neg_p0_q;
  logic            vld_p0_q;

  // Stage p0 valid bit: reset drops any pair in flight
  always_ff @(posedge clk) begin
    if (rst) vld_p0_q <= 1'b0;
    else     vld_p0_q <= in_valid;
  end

  // Stage p0 data: recoded partial products and carry-in bits, captured only for valid pairs
  always_ff @(posedge clk) begin
    if (in_valid) begin
      pp_p0_q  <= pp_d;
      neg_p0_q <= neg_d;
    end
  end

  assign sum_vld = vld_p0_q;
  assign sum_d   = booth_sum(pp_p0_q, neg_p0_q);
`else
  assign sum_vld = in_valid;
  assign sum_d   = booth_sum(pp_d, neg_d);
`endif

  // Output stage: the product updates only for valid pairs and holds its value across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= sum_vld;
      if (sum_vld) result_q <= sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (default build, or with BOOTH_PIPE_EN).
module tb_booth_multiplier;

`ifdef BOOTH_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic        out_valid;
  logic [15:0] result;

  booth_multiplier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a delay line of (valid, product) pairs.
  // It also tracks the last delivered product.
  logic        dv [LAT];
  logic [15:0] dp [LAT];
  logic        exp_ov = 1'b0;
  logic [15:0] exp_res = '0;
  bit          started = 0;
  logic [15:0] lit_q [$];

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    int p;
    sa = a;
    sb = b;
    p = sa * sb;
    return p[15:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) dv[k] = 1'b0;
      exp_ov  = 1'b0;
      exp_res = '0;
      started = 1;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        dv[k] = dv[k-1];
        dp[k] = dp[k-1];
      end
      dv[0] = in_valid;
      dp[0] = ref_mul(A, B);
      exp_ov = dv[LAT-1];
      if (exp_ov) exp_res = dp[LAT-1];
    end
  end

  // Compare process: checks both outputs every cycle, plus literal products when queued
  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (out_valid !== exp_ov || result !== exp_res) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: out_valid=%b result=%h, required out_valid=%b result=%h",
                 $time, out_valid, result, exp_ov, exp_res);
      end
      if (out_valid === 1'b1 && lit_q.size() > 0) begin
        logic [15:0] lit;
        lit = lit_q.pop_front();
        vectors++;
        if (result !== lit) begin
          miscompares++;
          $display("FAIL literal_product t=%0t: result=%h, required %h", $time, result, lit);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;
  vec_t dir [16];

  initial begin
    dir[0]  = '{8'd0,    8'd0,    16'h0000};
    dir[1]  = '{8'd5,    8'd6,    16'd30};
    dir[2]  = '{8'd127,  8'd127,  16'd16129};
    dir[3]  = '{8'h80,   8'h80,   16'h4000};
    dir[4]  = '{8'd100,  8'hFA,   16'hFDA8};
    dir[5]  = '{8'hF1,   8'd20,   16'hFED4};
    dir[6]  = '{8'd127,  8'h80,   16'hC080};
    dir[7]  = '{8'hFD,   8'hFC,   16'd12};
    dir[8]  = '{8'hAA,   8'd85,   16'hE372};
    dir[9]  = '{8'd85,   8'hAA,   16'hE372};
    dir[10] = '{8'd64,   8'hFF,   16'hFFC0};
    dir[11] = '{8'd73,   8'hED,   16'hFA95};
    dir[12] = '{8'd0,    8'h9C,   16'h0000};
    dir[13] = '{8'd1,    8'd1,    16'h0001};
    dir[14] = '{8'hFF,   8'hFF,   16'h0001};
    dir[15] = '{8'h80,   8'd127,  16'hC080};

    // Reset held for three cycles with a valid pair on the inputs
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'd5, 8'd6);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd5, 8'd6);

    // Back-to-back directed products, pinned to literal values
    for (int i = 0; i < 16; i++) begin
      lit_q.push_back(dir[i].p);
      drive(1'b0, 1'b1, dir[i].a, dir[i].b);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);

    // Bubble pattern: 16x8, invalid, -45x73
    lit_q.push_back(16'd128);
    drive(1'b0, 1'b1, 8'd16, 8'd8);
    drive(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    lit_q.push_back(16'hF32B);
    drive(1'b0, 1'b1, 8'hD3, 8'd73);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);

    // Reset arriving one cycle after a valid pair
    drive(1'b0, 1'b1, 8'd127, 8'd127);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);

    // Exhaustive stream of all operand pairs
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] idx;
      idx = 16'(i);
      drive(1'b0, 1'b1, idx[15:8], idx[7:0]);
    end

    // Random stream with bubbles and occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 64) == 0, ($urandom % 4) != 0, 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);

    @(negedge clk);
    vectors++;
    if (lit_q.size() != 0) begin
      miscompares++;
      $display("FAIL literal_drain: %0d products outstanding, required 0", lit_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
